hpdmc_ddr16_wrpath: RTL and testbench
=====================================

Name: hpdmc_ddr16_wrpath

Overview:
- Write-data path stage directly upstream of the 16-bit DQ output register banks (FDCE-based, clock-enabled) in the DDR16 memory controller.
- Buffers 32-bit write words with byte selects from the controller datapath in a small FIFO.
- After each write command, waits the SDRAM write latency, then drives one burst of rising/falling 16-bit halves, data masks, register clock enable and DQ/DQS output enables.

Parameters:
- WLAT, 2, cycles from wr_start to DQS preamble; legal range 1..15.
- BEATS, 2, 32-bit words per burst (BL4 on x16 DDR = 2 sys_clk cycles); legal range 1..8.
- FIFO_DEPTH, 4, write-word FIFO entries; must be a power of 2, at least BEATS.

Ports:
- sys_clk  in  1  system clock; all logic rising-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  FIFO can accept a word.
- wr_dat  in  32  write word; [31:16] goes out on the rising half, [15:0] on the falling half.
- wr_sel  in  4  byte enables, 1 = write byte; [3:2] apply to the rising half, [1:0] to the falling half.
- wr_start  in  1  write command issued to SDRAM this cycle (1-cycle pulse).
- busy  out  1  burst sequence in progress.
- do_r  out  16  rising-edge data to the output register bank.
- do_f  out  16  falling-edge data to the output register bank.
- dm_r  out  2  rising-edge DM; 1 = masked.
- dm_f  out  2  falling-edge DM; 1 = masked.
- do_ce  out  1  clock enable for the output register banks.
- dq_oe  out  1  DQ/DM drive enable.
- dqs_oe  out  1  DQS drive enable.
- underrun  out  1  1-cycle pulse: a data beat found the FIFO empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; state IDLE.
  - busy, do_ce, dq_oe, dqs_oe and underrun = 0.
  - do_r, do_f = 0; dm_r, dm_f = 2'b11.
  - wr_ready = 1.
- FIFO:
  - wr_ready = !full, combinational from registered count.
  - Push on wr_valid & wr_ready. A pop occurs on each DATA cycle with the FIFO non-empty.
  - Simultaneous push and pop leaves the count unchanged. Pop when full frees the slot only on the next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- FSM states: IDLE, WAIT, PRE, DATA, POST. All outputs are registered.
  - IDLE: wr_start -> WAIT, latency counter loaded with WLAT-1. If WLAT==1, go directly to PRE. wr_start is ignored in any other state.
  - WAIT: decrement the counter; at 0 -> PRE.
  - PRE: one cycle with dqs_oe=1, dq_oe=0.
  - DATA: BEATS cycles, beat counter 0..BEATS-1, with dqs_oe=1, dq_oe=1, do_ce=1. After the last beat -> POST.
  - POST: one cycle with dqs_oe=1, dq_oe=0, do_ce=0, then -> IDLE.
- Timing: wr_start in cycle T gives outputs asserted in these cycles:
  - dqs_oe: T+WLAT .. T+WLAT+BEATS+1.
  - dq_oe and do_ce: T+WLAT+1 .. T+WLAT+BEATS.
  - busy: T+1 .. T+WLAT+BEATS+1.
- Data beat:
  - do_r = head[31:16] and do_f = head[15:0].
  - dm_r = ~sel[3:2] and dm_f = ~sel[1:0].
- Empty at a data beat:
  - do_r = do_f = 0; dm_r = dm_f = 2'b11 (fully masked).
  - underrun = 1 for that cycle.
  - The beat still counts, so burst length is never stretched.
- Outside DATA: do_r, do_f, dm_r and dm_f hold their last value; do_ce = 0.
- Reset asserted mid-burst: dq_oe and dqs_oe drop immediately (async). Remaining FIFO contents are discarded.

Test Plan:
- Reset -> wr_ready=1, busy=0, dq_oe=dqs_oe=do_ce=0, dm_r=dm_f=2'b11.
- Push 0xAAAA5555/sel 4'hF and 0x12345678/sel 4'h3; wr_start at T=10, WLAT=2, BEATS=2:
  - dqs_oe high at 12..15, dq_oe and do_ce high at 13..14.
  - Cycle 13: do_r=0xAAAA, do_f=0x5555, dm=00/00.
  - Cycle 14: do_r=0x1234, do_f=0x5678, dm_r=2'b11, dm_f=2'b00.
  - busy high 11..15.
- Push 4 words with no pops -> wr_ready=0 after the fourth push; a fifth wr_valid is not accepted. The burst then pops 2 words, and wr_ready returns 1 in the cycle after the first pop.
- wr_start with 1 word queued -> beat 0 carries the data; beat 1 has dm=11/11 and data 0 with an underrun pulse; the sequence ends on schedule.
- Second wr_start pulsed during WAIT and during DATA -> ignored; exactly one burst is produced. With WLAT=1, the preamble appears in cycle T+1.
- Assert sys_rst_n=0 during the first DATA beat -> dq_oe and dqs_oe fall without waiting for a clock edge. After release: IDLE, FIFO empty, wr_ready=1.

Source files
------------

// File: rtl/hpdmc_ddr16_wrpath.sv
// hpdmc_ddr16_wrpath
//   Write-data path feeding the 16-bit DDR DQ output register banks.
//   Write words are queued in a small FIFO. Each write command starts a fixed
//   sequence: WLAT cycles of latency, one DQS preamble cycle, BEATS data
//   cycles and one DQS postamble cycle. Every data beat pops one 32-bit word
//   and splits it into rising/falling 16-bit halves with byte masks.
//
// Ports
//   sys_clk, sys_rst_n   clock (rising edge), async active-low reset
//   wr_valid/wr_ready    write word handshake into the FIFO
//   wr_dat, wr_sel       32-bit word ([31:16] rising half), byte enables
//   wr_start             write command pulse, starts one burst sequence
//   busy                 sequence in progress
//   do_r, do_f           rising/falling data to the output register banks
//   dm_r, dm_f           rising/falling data masks (1 = masked)
//   do_ce                clock enable of the output register banks
//   dq_oe, dqs_oe        DQ/DM and DQS drive enables
//   underrun             one-cycle pulse: a data beat found the FIFO empty
module hpdmc_ddr16_wrpath #(
  parameter int WLAT       = 2,
  parameter int BEATS      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_dat,
  input  logic [3:0]  wr_sel,
  input  logic        wr_start,
  output logic        busy,
  output logic [15:0] do_r,
  output logic [15:0] do_f,
  output logic [1:0]  dm_r,
  output logic [1:0]  dm_f,
  output logic        do_ce,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]    LAT_LOAD  = 4'(WLAT - 1);
  localparam logic [2:0]    BEAT_LAST = 3'(BEATS - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_DATA,
    S_POST
  } state_t;

  state_t        state;
  logic [3:0]    lat_cnt;
  logic [2:0]    beat_cnt;

  logic [35:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          load_beat;
  logic [35:0]   head;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rptr];

  // The output registers are loaded on the edge that enters each data cycle,
  // so the word for a beat is fetched in the cycle just before it is driven.
  assign load_beat = (state == S_PRE) || ((state == S_DATA) && (beat_cnt != BEAT_LAST));
  assign pop       = load_beat && !empty;

  // FIFO storage: {sel[3:0], dat[31:0]}; contents need no reset
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wptr] <= {wr_sel, wr_dat};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PTR_LAST) ? '0 : AW'(wptr + 1'b1);
      end
      if (pop) begin
        rptr <= (rptr == PTR_LAST) ? '0 : AW'(rptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Burst sequencer and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      do_ce    <= 1'b0;
      dq_oe    <= 1'b0;
      dqs_oe   <= 1'b0;
      underrun <= 1'b0;
      do_r     <= '0;
      do_f     <= '0;
      dm_r     <= 2'b11;
      dm_f     <= 2'b11;
    end else begin
      underrun <= 1'b0;

      if (load_beat) begin
        if (!empty) begin
          do_r <= head[31:16];
          do_f <= head[15:0];
          dm_r <= ~head[35:34];
          dm_f <= ~head[33:32];
        end else begin
          // Empty FIFO: drive a fully masked beat; the burst keeps its length
          do_r     <= '0;
          do_f     <= '0;
          dm_r     <= 2'b11;
          dm_f     <= 2'b11;
          underrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (wr_start) begin
            busy <= 1'b1;
            if (WLAT == 1) begin
              state  <= S_PRE;
              dqs_oe <= 1'b1;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        S_WAIT: begin
          // Counter reaching 0 after this decrement means PRE is next
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state  <= S_PRE;
            dqs_oe <= 1'b1;
          end
        end
        S_PRE: begin
          state    <= S_DATA;
          beat_cnt <= '0;
          dq_oe    <= 1'b1;
          do_ce    <= 1'b1;
        end
        S_DATA: begin
          if (beat_cnt == BEAT_LAST) begin
            state <= S_POST;
            dq_oe <= 1'b0;
            do_ce <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
          end
        end
        S_POST: begin
          state  <= S_IDLE;
          dqs_oe <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b0;
          do_ce  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_ddr16_wrpath.sv
module tb_hpdmc_ddr16_wrpath;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_dat;
  logic [3:0]  wr_sel;
  logic        wr_start;
  logic        busy;
  logic [15:0] do_r;
  logic [15:0] do_f;
  logic [1:0]  dm_r;
  logic [1:0]  dm_f;
  logic        do_ce;
  logic        dq_oe;
  logic        dqs_oe;
  logic        underrun;

  // WLAT=1 instance, only its sequencing is exercised
  logic        wr_valid1;
  logic        wr_ready1;
  logic [31:0] wr_dat1;
  logic [3:0]  wr_sel1;
  logic        wr_start1;
  logic        busy1;
  logic [15:0] do_r1;
  logic [15:0] do_f1;
  logic [1:0]  dm_r1;
  logic [1:0]  dm_f1;
  logic        do_ce1;
  logic        dq_oe1;
  logic        dqs_oe1;
  logic        underrun1;

  int n_cmp = 0;
  int n_bad = 0;

  hpdmc_ddr16_wrpath #(.WLAT(2), .BEATS(2), .FIFO_DEPTH(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat), .wr_sel(wr_sel),
    .wr_start(wr_start), .busy(busy), .do_r(do_r), .do_f(do_f),
    .dm_r(dm_r), .dm_f(dm_f), .do_ce(do_ce), .dq_oe(dq_oe), .dqs_oe(dqs_oe),
    .underrun(underrun)
  );

  hpdmc_ddr16_wrpath #(.WLAT(1), .BEATS(2), .FIFO_DEPTH(4)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_dat(wr_dat1), .wr_sel(wr_sel1),
    .wr_start(wr_start1), .busy(busy1), .do_r(do_r1), .do_f(do_f1),
    .dm_r(dm_r1), .dm_f(dm_f1), .do_ce(do_ce1), .dq_oe(dq_oe1), .dqs_oe(dqs_oe1),
    .underrun(underrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1;
    wr_dat   = d;
    wr_sel   = s;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic start_pulse();
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_dat    = '0;
    wr_sel    = '0;
    wr_start  = 1'b0;
    wr_valid1 = 1'b0;
    wr_dat1   = '0;
    wr_sel1   = '0;
    wr_start1 = 1'b0;

    // ---------------- reset state
    step(3);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {dq_oe, dqs_oe, do_ce}, 0);
    chk("rst_dm", {dm_r, dm_f}, 4'b1111);
    chk("rst_do", {do_r, do_f}, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    step(2);

    // ---------------- basic burst, WLAT=2
    push(32'hAAAA5555, 4'hF);
    push(32'h12345678, 4'h3);
    start_pulse();                          // now in T+1
    chk("b1_t1_busy", busy, 1);
    chk("b1_t1_dqs", dqs_oe, 0);
    step();                                 // T+2 preamble
    chk("b1_t2_oe", {dqs_oe, dq_oe, do_ce}, 3'b100);
    step();                                 // T+3 beat 0
    chk("b1_t3_oe", {dqs_oe, dq_oe, do_ce}, 3'b111);
    chk("b1_t3_data", {do_r, do_f}, 32'hAAAA5555);
    chk("b1_t3_dm", {dm_r, dm_f}, 4'b0000);
    step();                                 // T+4 beat 1
    chk("b1_t4_oe", {dqs_oe, dq_oe, do_ce}, 3'b111);
    chk("b1_t4_data", {do_r, do_f}, 32'h12345678);
    chk("b1_t4_dm", {dm_r, dm_f}, 4'b1100);
    chk("b1_t4_underrun", underrun, 0);
    step();                                 // T+5 postamble
    chk("b1_t5_oe", {dqs_oe, dq_oe, do_ce}, 3'b100);
    chk("b1_t5_busy", busy, 1);
    chk("b1_t5_hold", {do_r, do_f}, 32'h12345678);
    step();                                 // T+6 idle
    chk("b1_t6_busy", busy, 0);
    chk("b1_t6_dqs", dqs_oe, 0);
    step(2);

    // ---------------- FIFO full
    push(32'h11110000, 4'hF);
    chk("f_ready1", wr_ready, 1);
    push(32'h22220001, 4'hF);
    push(32'h33330002, 4'hF);
    push(32'h44440003, 4'hF);
    chk("f_ready_full", wr_ready, 0);
    push(32'hDEADBEEF, 4'hF);               // must be refused
    chk("f_ready_still_full", wr_ready, 0);
    start_pulse();                          // T+1
    chk("f_t1_ready", wr_ready, 0);
    step();                                 // T+2
    chk("f_t2_ready", wr_ready, 0);
    step();                                 // T+3
    chk("f_t3_data", {do_r, do_f}, 32'h11110000);
    step();                                 // T+4
    chk("f_t4_data", {do_r, do_f}, 32'h22220001);
    chk("f_t4_ready", wr_ready, 1);
    step(4);

    // ---------------- repeated wr_start in WAIT and DATA is ignored
    start_pulse();                          // T+1, WAIT
    wr_start = 1'b1;
    step();                                 // T+2
    wr_start = 1'b0;
    chk("i_t2_pre", {dqs_oe, dq_oe}, 2'b10);
    step();                                 // T+3
    chk("i_t3_data", {do_r, do_f}, 32'h33330002);
    wr_start = 1'b1;
    step();                                 // T+4
    wr_start = 1'b0;
    chk("i_t4_data", {do_r, do_f}, 32'h44440003);
    step();                                 // T+5
    chk("i_t5_post", {dqs_oe, dq_oe}, 2'b10);
    step();                                 // T+6
    chk("i_t6_busy", busy, 0);
    step();                                 // T+7
    chk("i_t7_quiet", {busy, dqs_oe, dq_oe}, 0);
    step();                                 // T+8
    chk("i_t8_quiet", {busy, dqs_oe, dq_oe}, 0);

    // ---------------- underrun with one word queued
    push(32'hCAFEF00D, 4'hC);
    start_pulse();
    step(2);                                // T+3
    chk("u_t3_data", {do_r, do_f}, 32'hCAFEF00D);
    chk("u_t3_dm", {dm_r, dm_f}, 4'b0011);
    chk("u_t3_underrun", underrun, 0);
    step();                                 // T+4
    chk("u_t4_data", {do_r, do_f}, 0);
    chk("u_t4_dm", {dm_r, dm_f}, 4'b1111);
    chk("u_t4_underrun", underrun, 1);
    chk("u_t4_oe", {dqs_oe, dq_oe, do_ce}, 3'b111);
    step();                                 // T+5
    chk("u_t5_underrun", underrun, 0);
    chk("u_t5_oe", {dqs_oe, dq_oe, do_ce}, 3'b100);
    step();                                 // T+6
    chk("u_t6_busy", busy, 0);
    step(2);

    // ---------------- WLAT=1 instance
    wr_start1 = 1'b1;
    step();                                 // T+1 preamble
    wr_start1 = 1'b0;
    chk("w1_t1", {busy1, dqs_oe1, dq_oe1}, 3'b110);
    step();                                 // T+2 beat 0
    chk("w1_t2", {dqs_oe1, dq_oe1, do_ce1}, 3'b111);
    step(2);                                // T+4 postamble
    chk("w1_t4", {dqs_oe1, dq_oe1, do_ce1}, 3'b100);
    step();                                 // T+5
    chk("w1_t5", {busy1, dqs_oe1}, 2'b00);
    step(2);

    // ---------------- reset during first data beat
    push(32'h01020304, 4'hF);
    push(32'h05060708, 4'hF);
    start_pulse();
    step(2);                                // T+3 beat 0
    chk("r_beat0_dq", dq_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_oe", {dq_oe, dqs_oe}, 2'b00);
    chk("r_async_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("r_after_ready", wr_ready, 1);
    chk("r_after_idle", {busy, dqs_oe, do_ce}, 0);
    start_pulse();                          // FIFO must be empty now
    step(2);                                // T+3
    chk("r_empty_underrun", underrun, 1);
    chk("r_empty_dm", {dm_r, dm_f}, 4'b1111);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
